// File: rtl/cpu_timing_sequencer_if.sv
// Decoder <-> timing sequencer handshake bundle.
// The decoder side (master) issues cycle requests and receives inst/cycle
// plus the arbitrated interrupt requests. The sequencer side (slave) owns
// the instruction register, T-state counter and interrupt arbitration.
interface cpu_timing_sequencer_if #(
   parameter int CYC_W = 3
);
   logic [7:0]       din;
   logic             icyc;
   logic             rcyc;
   logic             scyc;
   logic             sinst;
   logic             nmi_in;
   logic             irq_in;
   logic             irq_dis;
   logic [7:0]       inst;
   logic [CYC_W-1:0] cycle;
   logic             rst_req;
   logic             nmi_req;
   logic             irq_req;
   logic [1:0]       svc;
   logic             sync;
   logic             seq_err;

   modport master (
      output din, icyc, rcyc, scyc, sinst, nmi_in, irq_in, irq_dis,
      input  inst, cycle, rst_req, nmi_req, irq_req, svc, sync, seq_err
   );

   modport slave (
      input  din, icyc, rcyc, scyc, sinst, nmi_in, irq_in, irq_dis,
      output inst, cycle, rst_req, nmi_req, irq_req, svc, sync, seq_err
   );
endinterface

// File: rtl/cpu_timing_sequencer.sv
// CPU timing sequencer: instruction register, T-state counter and
// reset/NMI/IRQ arbitration feeding the instruction decoder.
// Optional macro SEQ_CYCLE_GUARD_EN: when defined, icyc at the last
// T-state behaves like rcyc (opcode fetch/injection) instead of a plain
// wrap with inst held. seq_err is set in both builds.
// Note: while scyc stalls, sinst is ignored along with the rest of the
// cycle logic (svc holds); only interrupt capture keeps running.
module cpu_timing_sequencer #(
   parameter logic [7:0] INT_OPCODE = 8'h00,
   parameter int         CYC_W      = 3
) (
   input logic                   clk,
   input logic                   clr,
   cpu_timing_sequencer_if.slave bus
);
   localparam logic [1:0] SVC_NONE = 2'd0;
   localparam logic [1:0] SVC_RST  = 2'd1;
   localparam logic [1:0] SVC_NMI  = 2'd2;
   localparam logic [1:0] SVC_IRQ  = 2'd3;

   logic [7:0]       inst_r;
   logic [CYC_W-1:0] cycle_r;
   logic             rst_r, nmi_r, irq_r, err_r;
   logic [1:0]       svc_r;
   // nmi_s1 samples the raw line; nmi_s2 is the previous sample
   logic             nmi_s1, nmi_s2;

   logic             nmi_edge;
   logic             pend;
   logic             cyc_last;
   logic             fetch;
   logic             ovf;

   // Decode the request priority for this edge (scyc blocks everything below it)
   always_comb begin
      nmi_edge = nmi_s1 & ~nmi_s2;
      pend     = rst_r | nmi_r | irq_r;
      cyc_last = (cycle_r == {CYC_W{1'b1}});
      ovf      = ~bus.scyc & ~bus.rcyc & bus.icyc & cyc_last;
`ifdef SEQ_CYCLE_GUARD_EN
      fetch    = ~bus.scyc & (bus.rcyc | ovf);
`else
      fetch    = ~bus.scyc & bus.rcyc;
`endif
   end

   // Sequencer state: reset, stall, fetch/advance, and interrupt arbitration
   always_ff @(posedge clk) begin
      if (clr) begin
         inst_r  <= INT_OPCODE;
         cycle_r <= '0;
         rst_r   <= 1'b1;
         nmi_r   <= 1'b0;
         irq_r   <= 1'b0;
         svc_r   <= SVC_NONE;
         err_r   <= 1'b0;
         nmi_s1  <= 1'b0;
         nmi_s2  <= 1'b0;
      end else begin
         nmi_s1 <= bus.nmi_in;
         nmi_s2 <= nmi_s1;
         irq_r  <= bus.irq_in & ~bus.irq_dis;
         nmi_r  <= nmi_r | nmi_edge;

         if (fetch) begin
            cycle_r <= '0;
            inst_r  <= pend ? INT_OPCODE : bus.din;
            svc_r   <= SVC_NONE;
         end else if (~bus.scyc & bus.icyc) begin
            cycle_r <= cycle_r + 1'b1;
         end

         if (ovf)
            err_r <= 1'b1;

         // Service acceptance; a fresh NMI edge on the same edge keeps nmi_req set
         if (~bus.scyc & bus.sinst) begin
            if (rst_r) begin
               svc_r <= SVC_RST;
               rst_r <= 1'b0;
            end else if (nmi_r) begin
               svc_r <= SVC_NMI;
               nmi_r <= nmi_edge;
            end else if (irq_r) begin
               svc_r <= SVC_IRQ;
            end else begin
               svc_r <= SVC_NONE;
            end
         end
      end
   end

   assign bus.inst    = inst_r;
   assign bus.cycle   = cycle_r;
   assign bus.rst_req = rst_r;
   assign bus.nmi_req = nmi_r;
   assign bus.irq_req = irq_r;
   assign bus.svc     = svc_r;
   assign bus.sync    = (cycle_r == '0);
   assign bus.seq_err = err_r;
endmodule

// File: tb/tb_cpu_timing_sequencer.sv
// Directed bench for cpu_timing_sequencer: reset, fetch, NMI, IRQ masking,
// stall priority and cycle overflow with hand-computed expectations.
module tb_cpu_timing_sequencer;
   logic clk = 1'b0;
   logic clr;
   int   n_cmp = 0;
   int   n_bad = 0;

   cpu_timing_sequencer_if #(.CYC_W(3)) bus ();

   cpu_timing_sequencer #(.INT_OPCODE(8'h00), .CYC_W(3)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // One clock edge with the given one-shot requests, then drop them
   task automatic tick(input logic i, input logic r, input logic s, input logic si, input logic [7:0] d);
      bus.icyc  = i;
      bus.rcyc  = r;
      bus.scyc  = s;
      bus.sinst = si;
      bus.din   = d;
      @(posedge clk);
      #1;
      bus.icyc  = 1'b0;
      bus.rcyc  = 1'b0;
      bus.scyc  = 1'b0;
      bus.sinst = 1'b0;
   endtask

   task automatic icyc_n(input int n);
      for (int k = 0; k < n; k++) tick(1, 0, 0, 0, 8'h00);
   endtask

   initial begin
      clr = 1'b1;
      bus.din = 8'h00; bus.icyc = 0; bus.rcyc = 0; bus.scyc = 0; bus.sinst = 0;
      bus.nmi_in = 0; bus.irq_in = 0; bus.irq_dis = 0;

      // Reset then sequence
      tick(0, 0, 0, 0, 8'h00);
      tick(0, 0, 0, 0, 8'h00);
      chk("rst_inst", bus.inst, 8'h00);
      chk("rst_cycle", bus.cycle, 0);
      chk("rst_req", bus.rst_req, 1);
      chk("rst_nmi", bus.nmi_req, 0);
      chk("rst_irq", bus.irq_req, 0);
      chk("rst_svc", bus.svc, 0);
      chk("rst_err", bus.seq_err, 0);
      chk("rst_sync", bus.sync, 1);
      clr = 1'b0;
      tick(0, 0, 0, 1, 8'h00);
      chk("sinst_svc", bus.svc, 1);
      chk("sinst_rst", bus.rst_req, 0);
      chk("sinst_inst", bus.inst, 8'h00);
      icyc_n(7);
      chk("c7_cycle", bus.cycle, 7);
      chk("c7_sync", bus.sync, 0);
      tick(0, 1, 0, 0, 8'hA9);
      chk("a9_inst", bus.inst, 8'hA9);
      chk("a9_cycle", bus.cycle, 0);
      chk("a9_svc", bus.svc, 0);

      // Opcode fetch
      tick(0, 1, 0, 0, 8'h69);
      chk("69_inst", bus.inst, 8'h69);
      chk("69_sync", bus.sync, 1);
      icyc_n(3);
      chk("69_cycle", bus.cycle, 3);
      chk("69_sync3", bus.sync, 0);

      // NMI during instruction: two-edge latency
      tick(0, 1, 0, 0, 8'hAD);
      icyc_n(2);
      bus.nmi_in = 1;
      tick(1, 0, 0, 0, 8'h00);
      chk("nmi_lat1", bus.nmi_req, 0);
      tick(0, 0, 0, 0, 8'h00);
      chk("nmi_lat2", bus.nmi_req, 1);
      tick(0, 1, 0, 0, 8'hEA);
      chk("nmi_inj", bus.inst, 8'h00);
      tick(0, 0, 0, 1, 8'h00);
      chk("nmi_svc", bus.svc, 2);
      chk("nmi_clr", bus.nmi_req, 0);
      tick(0, 0, 0, 0, 8'h00);
      chk("nmi_level", bus.nmi_req, 0);

      // New NMI edge on the clearing edge keeps nmi_req set
      bus.nmi_in = 0;
      tick(0, 0, 0, 0, 8'h00);
      tick(0, 0, 0, 0, 8'h00);
      bus.nmi_in = 1;
      tick(0, 0, 0, 0, 8'h00);
      bus.nmi_in = 0;
      tick(0, 0, 0, 0, 8'h00);
      chk("nmi2_set", bus.nmi_req, 1);
      bus.nmi_in = 1;
      tick(0, 0, 0, 0, 8'h00);
      tick(0, 0, 0, 1, 8'h00);
      chk("nmi2_svc", bus.svc, 2);
      chk("nmi2_keep", bus.nmi_req, 1);
      tick(0, 0, 0, 1, 8'h00);
      chk("nmi2_clr", bus.nmi_req, 0);
      bus.nmi_in = 0;

      // IRQ masking
      bus.irq_in = 1; bus.irq_dis = 1;
      tick(0, 1, 0, 0, 8'hE8);
      chk("irq_mask_inst", bus.inst, 8'hE8);
      chk("irq_mask_req", bus.irq_req, 0);
      bus.irq_dis = 0;
      tick(0, 0, 0, 0, 8'h00);
      chk("irq_unmask", bus.irq_req, 1);
      tick(0, 1, 0, 0, 8'hEA);
      chk("irq_inj", bus.inst, 8'h00);
      tick(0, 0, 0, 1, 8'h00);
      chk("irq_svc", bus.svc, 3);
      chk("irq_level", bus.irq_req, 1);
      bus.irq_in = 0;
      tick(0, 0, 0, 0, 8'h00);
      chk("irq_drop", bus.irq_req, 0);

      // Stall and priority
      tick(0, 1, 0, 0, 8'h20);
      icyc_n(4);
      chk("st_pre", bus.cycle, 4);
      bus.irq_in = 1;
      tick(1, 1, 1, 0, 8'h55);
      chk("st_cycle", bus.cycle, 4);
      chk("st_inst", bus.inst, 8'h20);
      chk("st_irq", bus.irq_req, 1);
      bus.irq_in = 0;
      tick(0, 0, 0, 0, 8'h00);
      chk("idle_cycle", bus.cycle, 4);
      tick(1, 1, 0, 0, 8'h55);
      chk("ri_cycle", bus.cycle, 0);
      chk("ri_inst", bus.inst, 8'h55);

      // Overflow
      icyc_n(7);
      chk("ov_pre_err", bus.seq_err, 0);
      tick(1, 0, 0, 0, 8'hC8);
      chk("ov_cycle", bus.cycle, 0);
      chk("ov_err", bus.seq_err, 1);
`ifdef SEQ_CYCLE_GUARD_EN
      chk("ov_inst", bus.inst, 8'hC8);
`else
      chk("ov_inst", bus.inst, 8'h55);
`endif
      icyc_n(2);
      chk("ov_sticky", bus.seq_err, 1);
      clr = 1'b1;
      tick(0, 0, 0, 0, 8'h00);
      clr = 1'b0;
      chk("clr_err", bus.seq_err, 0);
      chk("clr_cycle", bus.cycle, 0);
      chk("clr_rst", bus.rst_req, 1);
      chk("clr_inst", bus.inst, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/cpu_timing_sequencer.md
Name: cpu_timing_sequencer

Overview:
- Drives the `inst`/`cycle` pair that the instruction decoder consumes, and acts on the decoder's `icyc`/`rcyc`/`scyc`/`sinst` requests.
- Holds the instruction register and the 3-bit T-state counter.
- Captures the opcode from the data bus on fetch; injects the interrupt opcode (0x00) when a request is pending.
- Arbitrates reset, NMI and IRQ and presents them to the decoder as `rst_req`/`nmi_req`/`irq_req`.

Parameters:
- INT_OPCODE, 8'h00, opcode loaded into `inst` on reset and on interrupt injection.
- CYC_W, 3, width of the cycle counter. Fixed; the decoder decodes 3'b000..3'b111.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- clr  in  1  reset, synchronous, active-high.
- din  in  8  data bus input; opcode source on fetch.
- icyc  in  1  decoder request: advance cycle by 1.
- rcyc  in  1  decoder request: end of instruction; fetch the next opcode, cycle to 0.
- scyc  in  1  decoder request: stall; hold all state.
- sinst  in  1  decoder request: interrupt sequence accepted; latch the serviced source.
- nmi_in  in  1  raw NMI line, active-high, edge-sensitive.
- irq_in  in  1  raw IRQ line, active-high, level-sensitive.
- irq_dis  in  1  I flag from the status register.
- inst  out  8  current instruction register, to the decoder.
- cycle  out  3  current T-state, to the decoder.
- rst_req  out  1  reset sequence pending.
- nmi_req  out  1  NMI pending.
- irq_req  out  1  unmasked IRQ pending.
- svc  out  2  source being serviced: 0 none, 1 reset, 2 NMI, 3 IRQ.
- sync  out  1  high when `cycle` == 0 (opcode cycle).
- seq_err  out  1  sticky flag: `icyc` received at cycle 7.

Behaviour:
- **Reset.** While `clr`=1 at a clock edge:
  - inst=INT_OPCODE, cycle=0, rst_req=1, nmi_req=0, irq_req=0, svc=0, seq_err=0, nmi edge register=0.
  - `sync`=1 after the first reset edge.
  - `clr` asserted mid-instruction aborts it immediately; there is no partial completion.
- **Priority per edge.** clr > scyc > rcyc > icyc. Only the highest-priority request acts.
- **scyc.** inst, cycle and svc hold. Interrupt capture still runs: the NMI edge is latched and irq_req is updated.
- **rcyc.**
  - cycle <= 0.
  - If rst_req | nmi_req | irq_req (values before the edge): inst <= INT_OPCODE. Otherwise inst <= din.
  - svc <= 0.
- **icyc.** cycle <= cycle + 1.
  - At cycle 7 the result wraps to 0 and seq_err <= 1.
  - `inst` is unchanged.
- **No request.** All state holds.
- **sinst.** Independent of the cycle logic; acts on the same edge as icyc/rcyc.
  - svc <= highest pending source: reset > NMI > IRQ.
  - The chosen pending flag clears: rst_req <= 0, or nmi_req <= 0.
  - IRQ is not cleared; it is level-driven.
  - sinst with nothing pending: svc <= 0 and no flag changes.
- **NMI.**
  - nmi_req is set on a rising edge of `nmi_in`, detected against the previous registered sample (one-flop delay).
  - A new edge on the same cycle that sinst clears NMI wins: nmi_req stays 1.
- **IRQ.** irq_req <= irq_in & ~irq_dis, registered every cycle; one cycle of latency.
- **sync.** Combinational: sync = (cycle == 0).
- **Latency.**
  - Opcode on `din` at a rcyc edge is visible on `inst` the next cycle.
  - An NMI edge is visible on nmi_req 2 edges after `nmi_in` rises.

Optional Feature:
- Macro: SEQ_CYCLE_GUARD_EN.
- **Defined:** `icyc` at cycle 7 is treated as `rcyc`: opcode fetch/injection, cycle <= 0, and seq_err <= 1.
- **Undefined:** plain wrap to 0 with `inst` held; seq_err is still set.

Test Plan:
- **Reset then sequence.** clr high 2 cycles then low, decoder model issues sinst at cycle 0 → inst=0x00, svc=1, rst_req=0 the next cycle; 7 icyc then rcyc with din=0xA9 → inst=0xA9, cycle=0.
- **Opcode fetch.** din=0x69 and rcyc while no request pending → inst=0x69, cycle=0, sync=1; then icyc ×3 → cycle=3, sync=0.
- **NMI during instruction.** nmi_in rises at cycle 2 of 0xAD → nmi_req=1 two edges later; next rcyc with din=0xEA → inst=0x00 (not 0xEA); sinst → svc=2, nmi_req=0.
- **IRQ masking.** irq_in=1, irq_dis=1, rcyc with din=0xE8 → inst=0xE8, irq_req=0; drop irq_dis → irq_req=1 next cycle; next rcyc → inst=0x00.
- **Stall and priority.** scyc+rcyc+icyc together at cycle 4 → cycle stays 4 and inst holds; rcyc+icyc together → cycle=0.
- **Overflow.** icyc at cycle 7 → seq_err=1 and cycle=0; inst held without SEQ_CYCLE_GUARD_EN, inst=din with it. Then clr → seq_err=0.
